// File: rtl/pipeline_hazard_unit_if.sv
// Hazard unit bundle: pipeline-side register/control
// fields in, stall/flush/forward controls out.
interface pipeline_hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;
  logic                  branch_taken;
  logic                  pc_write_en;
  logic                  if_id_write_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;

  modport master (
    output id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd,
    output ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write,
    output wb_rd, wb_reg_write,
    output branch_taken,
    input  pc_write_en, if_id_write_en,
    input  if_id_flush, id_ex_flush,
    input  fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd,
    input  ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write,
    input  wb_rd, wb_reg_write,
    input  branch_taken,
    output pc_write_en, if_id_write_en,
    output if_id_flush, id_ex_flush,
    output fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, branch flush and EX forwarding control.
// HAZARD_STATS_EN adds saturating stall/flush counters.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W          = 5,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W               = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_unit_if.slave   hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]        stall_count,
  output logic [CNT_W-1:0]        flush_count
`endif
);

  localparam int MAXC =
    (LOAD_STALL_CYCLES > BRANCH_FLUSH_CYCLES) ?
    LOAD_STALL_CYCLES : BRANCH_FLUSH_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam bit LS_MULTI = LOAD_STALL_CYCLES > 1;
  localparam bit BF_MULTI = BRANCH_FLUSH_CYCLES > 1;
  localparam logic [CW-1:0] LS_INIT =
    LS_MULTI ? CW'(LOAD_STALL_CYCLES - 2) : '0;
  localparam logic [CW-1:0] BF_INIT =
    BF_MULTI ? CW'(BRANCH_FLUSH_CYCLES - 2) : '0;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            rs1_hit, rs2_hit, hazard;
  logic            flush_mode, stall_mode;
  logic            pc_we, ifid_we, ifid_fl, idex_fl;
  logic [1:0]      fa, fb;

  assign rs1_hit = hz.id_uses_rs1 &&
                   (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit = hz.id_uses_rs2 &&
                   (hz.id_rs2 == hz.ex_rd);
  assign hazard  = hz.ex_mem_read &&
                   hz.ex_reg_write &&
                   (hz.ex_rd != X0) &&
                   (rs1_hit || rs2_hit);

  assign flush_mode = reset &&
    (hz.branch_taken || state == FLUSH);
  assign stall_mode = reset && !flush_mode &&
    (state == STALL || (state == RUN && hazard));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (hz.branch_taken) begin
      state_n = BF_MULTI ? FLUSH : RUN;
      cnt_n   = BF_INIT;
    end else begin
      unique case (state)
        RUN: begin
          if (hazard && LS_MULTI) begin
            state_n = STALL;
            cnt_n   = LS_INIT;
          end
        end
        default: begin
          if (cnt == '0) state_n = RUN;
          else cnt_n = cnt - 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    unique case (1'b1)
      !reset: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end
      flush_mode: begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end
      stall_mode: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_fl = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we
  );
    if (m_we && m_rd != X0 && m_rd == rs)
      return 2'b10;
    else if (w_we && w_rd != X0 && w_rd == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // MEM is the younger result, so it wins over WB
  assign fa = !reset ? 2'b00 :
    fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write,
            hz.wb_rd, hz.wb_reg_write);
  assign fb = !reset ? 2'b00 :
    fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write,
            hz.wb_rd, hz.wb_reg_write);

  assign hz.pc_write_en    = pc_we;
  assign hz.if_id_write_en = ifid_we;
  assign hz.if_id_flush    = ifid_fl;
  assign hz.id_ex_flush    = idex_fl;
  assign hz.fwd_a_sel      = fa;
  assign hz.fwd_b_sel      = fb;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_we && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (flush_mode && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule
